// File: rtl/regfile_mp.sv
// Multi-ported register file with two write ports, write-to-read bypass,
// a per-register pending scoreboard and a non-bypassed debug read port.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]          o_rd_busy,
    input  logic                       i_w0_en,
    input  logic [ADDR_W-1:0]          i_w0_addr,
    input  logic [DATA_W-1:0]          i_w0_data,
    input  logic                       i_w1_en,
    input  logic [ADDR_W-1:0]          i_w1_addr,
    input  logic [DATA_W-1:0]          i_w1_data,
    input  logic                       i_sb_set,
    input  logic [ADDR_W-1:0]          i_sb_addr,
    input  logic                       i_flush,
    input  logic [ADDR_W-1:0]          i_dbg_addr,
    output logic [DATA_W-1:0]          o_dbg_data,
    output logic [(2**ADDR_W)-1:0]     o_pending
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [DEPTH-1:0] KEEP_MASK =
        (ZERO_REG != 0) ? {{(DEPTH-1){1'b1}}, 1'b0} : {DEPTH{1'b1}};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  pending_r;
    logic [DEPTH-1:0]  pending_nxt_s;
    logic [DEPTH-1:0]  set_s;
    logic [DEPTH-1:0]  clr_s;
    logic              w0_ok_s;
    logic              w1_ok_s;
    logic              sb_ok_s;

    // Writes and sets aimed at a hard-wired zero register are dropped here.
    assign w0_ok_s = i_w0_en  && !((ZERO_REG != 0) && (i_w0_addr == {ADDR_W{1'b0}}));
    assign w1_ok_s = i_w1_en  && !((ZERO_REG != 0) && (i_w1_addr == {ADDR_W{1'b0}}));
    assign sb_ok_s = i_sb_set && !((ZERO_REG != 0) && (i_sb_addr == {ADDR_W{1'b0}}));

    // Register storage; w1 is assigned last so it wins on an address clash.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < DEPTH; n++) begin
                mem_r[n] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w0_ok_s) begin
                mem_r[i_w0_addr] <= i_w0_data;
            end
            if (w1_ok_s) begin
                mem_r[i_w1_addr] <= i_w1_data;
            end
        end
    end

    // Scoreboard next state: set beats write-clear, flush beats everything.
    always_comb begin
        set_s         = {DEPTH{1'b0}};
        clr_s         = {DEPTH{1'b0}};
        pending_nxt_s = {DEPTH{1'b0}};
        for (int n = 0; n < DEPTH; n++) begin
            set_s[n] = sb_ok_s && (i_sb_addr == ADDR_W'(n));
            clr_s[n] = (w0_ok_s && (i_w0_addr == ADDR_W'(n))) ||
                       (w1_ok_s && (i_w1_addr == ADDR_W'(n)));
        end
        if (i_flush) begin
            pending_nxt_s = {DEPTH{1'b0}};
        end else begin
            pending_nxt_s = ((pending_r & ~clr_s) | set_s) & KEEP_MASK;
        end
    end

    // Pending bitmap register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_r <= {DEPTH{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign o_pending  = pending_r;
    assign o_dbg_data = ((ZERO_REG != 0) && (i_dbg_addr == {ADDR_W{1'b0}})) ?
                        {DATA_W{1'b0}} : mem_r[i_dbg_addr];

    // Read ports are gated by reset so an in-flight write cannot bypass out.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              zero_s;
        logic              hit0_s;
        logic              hit1_s;

        assign addr_s = i_rd_addr[k*ADDR_W +: ADDR_W];
        assign zero_s = (ZERO_REG != 0) && (addr_s == {ADDR_W{1'b0}});
        assign hit0_s = w0_ok_s && (i_w0_addr == addr_s);
        assign hit1_s = w1_ok_s && (i_w1_addr == addr_s);

        assign o_rd_data[k*DATA_W +: DATA_W] =
            (!i_rst_n || zero_s) ? {DATA_W{1'b0}} :
            hit1_s               ? i_w1_data      :
            hit0_s               ? i_w0_data      :
                                   mem_r[addr_s];

        assign o_rd_busy[k] = i_rst_n && pending_r[addr_s] && !(hit0_s || hit1_s);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and random checks of regfile_mp against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [AW-1:0]  ra0, ra1, w0a, w1a, sba, dbga;
    logic           w0e, w1e, sbs, flush;
    logic [DW-1:0]  w0d, w1d;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [DW-1:0]    dbg_data;
    logic [DEPTH-1:0] pending;

    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_pend [DEPTH];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rd_addr = {ra1, ra0};

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
        .i_w0_en(w0e), .i_w0_addr(w0a), .i_w0_data(w0d),
        .i_w1_en(w1e), .i_w1_addr(w1a), .i_w1_data(w1d),
        .i_sb_set(sbs), .i_sb_addr(sba), .i_flush(flush),
        .i_dbg_addr(dbga), .o_dbg_data(dbg_data), .o_pending(pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic hits(input logic [AW-1:0] a);
        return (w0e && w0a == a) || (w1e && w1a == a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (w1e && w1a == a) return w1d;
        if (w0e && w0a == a) return w0d;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [AW-1:0] a);
        if (!rst_n) return 32'd0;
        return {31'd0, m_pend[a] && !hits(a)};
    endfunction

    function automatic logic [31:0] exp_pend();
        logic [31:0] v;
        v = 32'd0;
        for (int n = 0; n < DEPTH; n++) v[n] = m_pend[n];
        return v;
    endfunction

    function automatic logic [31:0] exp_dbg(input logic [AW-1:0] a);
        if (a == 5'd0) return 32'd0;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < DEPTH; n++) begin
            m_mem[n]  = 32'd0;
            m_pend[n] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " rd0"},   rd_data[31:0],       exp_rd(ra0));
        check({tag, " rd1"},   rd_data[63:32],      exp_rd(ra1));
        check({tag, " busy0"}, {31'd0, rd_busy[0]}, exp_busy(ra0));
        check({tag, " busy1"}, {31'd0, rd_busy[1]}, exp_busy(ra1));
        check({tag, " pend"},  pending,             exp_pend());
        check({tag, " dbg"},   dbg_data,            exp_dbg(dbga));
    endtask

    // Advance one clock; the model applies this cycle's writes/sets if not in reset.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                for (int n = 0; n < DEPTH; n++) m_pend[n] = 1'b0;
            end else begin
                for (int n = 0; n < DEPTH; n++) if (hits(AW'(n))) m_pend[n] = 1'b0;
                if (sbs && sba != 5'd0) m_pend[sba] = 1'b1;
            end
            if (w0e && w0a != 5'd0) m_mem[w0a] = w0d;
            if (w1e && w1a != 5'd0) m_mem[w1a] = w1d;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        w0e = 1'b0; w1e = 1'b0; sbs = 1'b0; flush = 1'b0;
        w0a = 5'd0; w1a = 5'd0; sba = 5'd0;
        w0d = 32'd0; w1d = 32'd0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        model_reset();
        idle();
        ra0 = 5'd3; ra1 = 5'd0; dbga = 5'd3;
        rst_n = 1'b0;
        // Writes and sets during reset must be ignored and outputs held at zero.
        w0e = 1'b1; w0a = 5'd3; w0d = 32'hCAFE_F00D; sbs = 1'b1; sba = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_all("in_reset");
        idle();
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            ra0 = AW'(a); ra1 = AW'(31 - a); dbga = AW'(a);
            #1 check_all("post_reset");
            check("post_reset zero0", rd_data[31:0], 32'd0);
            tick();
        end

        // Bypass of a w0 write, then the stored value on the debug port.
        w0e = 1'b1; w0a = 5'd5; w0d = 32'hDEAD_BEEF; ra0 = 5'd5; dbga = 5'd5;
        #1 check_all("bypass5");
        check("bypass5 const", rd_data[31:0], 32'hDEAD_BEEF);
        check("dbg5 before", dbg_data, 32'd0);
        tick();
        idle();
        #1 check("dbg5 after", dbg_data, 32'hDEAD_BEEF);

        // Both write ports on one address: w1 wins.
        w0e = 1'b1; w0a = 5'd7; w0d = 32'h11; w1e = 1'b1; w1a = 5'd7; w1d = 32'h22;
        ra0 = 5'd7; ra1 = 5'd7;
        #1 check_all("dual7");
        check("dual7 bypass", rd_data[63:32], 32'h22);
        tick();
        idle(); dbga = 5'd7;
        #1 check("dual7 stored", dbg_data, 32'h22);

        // Register zero ignores writes and scoreboard sets.
        w0e = 1'b1; w0a = 5'd0; w0d = 32'hFFFF_FFFF; sbs = 1'b1; sba = 5'd0; ra0 = 5'd0; dbga = 5'd0;
        #1 check_all("zero_w");
        tick();
        idle();
        #1 check("zero rd", rd_data[31:0], 32'd0);
        check("zero pend", {31'd0, pending[0]}, 32'd0);

        // Scoreboard set, set beating write-clear, then flush.
        sbs = 1'b1; sba = 5'd3; ra0 = 5'd3; ra1 = 5'd4;
        #1 check_all("sb_set3");
        tick();
        idle();
        #1 check("sb3 busy", {31'd0, rd_busy[0]}, 32'd1);
        w1e = 1'b1; w1a = 5'd3; w1d = 32'h3333; sbs = 1'b1; sba = 5'd3;
        #1 check_all("sb3 bypass");
        tick();
        idle();
        #1 check("sb3 set wins", {31'd0, rd_busy[0]}, 32'd1);
        flush = 1'b1; sbs = 1'b1; sba = 5'd4; w0e = 1'b1; w0a = 5'd4; w0d = 32'h4444;
        #1 check_all("flush");
        tick();
        idle();
        #1 check("flush pend", pending, 32'd0);
        check_all("after_flush");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            w0e = 1'($urandom_range(0, 1)); w0a = rand_addr(); w0d = $urandom();
            w1e = 1'($urandom_range(0, 1)); w1a = rand_addr(); w1d = $urandom();
            sbs = 1'($urandom_range(0, 1)); sba = rand_addr();
            flush = ($urandom_range(0, 15) == 0);
            ra0 = rand_addr(); ra1 = rand_addr(); dbga = rand_addr();
            #1 check_all("rand");
            tick();
        end

        // Asynchronous reset between edges clears storage without a clock.
        idle();
        w0e = 1'b1; w0a = 5'd9; w0d = 32'h1234;
        tick();
        idle(); ra0 = 5'd9; ra1 = 5'd9; dbga = 5'd9;
        #1 check("x9 stored", rd_data[31:0], 32'h1234);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("x9 async rst", rd_data[31:0], 32'd0);
        check_all("async_rst");
        w0e = 1'b1; w0a = 5'd9; w0d = 32'hFF; sbs = 1'b1; sba = 5'd9;
        tick();
        #1 check_all("rst_held");
        idle();
        rst_n = 1'b1;
        #1 check_all("rst_release");
        check("x9 after rst", dbg_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
